// File: rtl/uart_receiver.sv
// Oversampling UART receiver with a majority-voted bit decision, optional parity and
// registered one-cycle status pulses.
module uart_receiver #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_in,
  input  logic [5:0]            prescale,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  stop_error
);

  localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                 state;
  logic [5:0]             p_lat;
  logic                   par_en_lat;
  logic                   par_odd_lat;
  logic [5:0]             edge_cnt;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [DATA_WIDTH-1:0]  shift_reg;
  logic [2:0]             samples;
  logic                   parity_flag;

  logic [5:0]             prescale_eff;
  logic [5:0]             half;
  logic                   bit_end;
  logic                   voted;
  logic                   expected_parity;

  // Unsupported oversampling factors fall back to 16.
  always_comb begin
    prescale_eff = 6'd16;
    case (prescale)
      6'd8:    prescale_eff = 6'd8;
      6'd32:   prescale_eff = 6'd32;
      default: prescale_eff = 6'd16;
    endcase
  end

  assign half            = {1'b0, p_lat[5:1]};
  assign bit_end         = (edge_cnt == p_lat - 6'd1);
  assign voted           = (samples[0] & samples[1]) | (samples[0] & samples[2]) |
                           (samples[1] & samples[2]);
  assign expected_parity = par_odd_lat ? ~^shift_reg : ^shift_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      p_lat        <= 6'd16;
      par_en_lat   <= 1'b0;
      par_odd_lat  <= 1'b0;
      edge_cnt     <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      samples      <= '0;
      parity_flag  <= 1'b0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
    end else begin
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;

      // Three samples around mid-bit feed the vote used at the bit's last count.
      if (state != IDLE) begin
        edge_cnt <= bit_end ? 6'd0 : edge_cnt + 6'd1;
        if (edge_cnt == half - 6'd1) samples[0] <= rx_in;
        if (edge_cnt == half)        samples[1] <= rx_in;
        if (edge_cnt == half + 6'd1) samples[2] <= rx_in;
      end

      case (state)
        IDLE: begin
          edge_cnt <= 6'd0;
          if (!rx_in) begin
            state       <= START;
            p_lat       <= prescale_eff;
            par_en_lat  <= parity_enable;
            par_odd_lat <= parity_type;
            bit_cnt     <= '0;
            parity_flag <= 1'b0;
          end
        end

        START: begin
          if (bit_end) state <= voted ? IDLE : DATA;
        end

        DATA: begin
          if (bit_end) begin
            shift_reg <= {voted, shift_reg[DATA_WIDTH-1:1]};
            if (bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1)) begin
              bit_cnt <= '0;
              state   <= par_en_lat ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        PARITY: begin
          if (bit_end) begin
            if (voted != expected_parity) parity_flag <= 1'b1;
            state <= STOP;
          end
        end

        STOP: begin
          // Status is reported on the cycle the receiver is already back in IDLE.
          if (bit_end) begin
            state        <= IDLE;
            parity_error <= parity_flag;
            stop_error   <= ~voted;
            if (voted && !parity_flag) begin
              data_valid <= 1'b1;
              data_out   <= shift_reg;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: drives hand-built serial frames and checks the
// status pulses, received words and frame latency.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_in;
  logic [5:0] prescale;
  logic       parity_enable;
  logic       parity_type;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_error;
  logic       stop_error;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int validCount = 0;
  int perrCount = 0;
  int serrCount = 0;
  int startCycle = 0;
  int validCycle = 0;
  logic [7:0] dataLog [4];

  uart_receiver #(.DATA_WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_in        (rx_in),
    .prescale     (prescale),
    .parity_enable(parity_enable),
    .parity_type  (parity_type),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .parity_error (parity_error),
    .stop_error   (stop_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Pulse monitor sampled on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (reset) begin
      if (data_valid) begin
        if (validCount < 4) dataLog[validCount] = data_out;
        validCount++;
        validCycle = cycle;
      end
      if (parity_error) perrCount++;
      if (stop_error) serrCount++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearCounts();
    validCount = 0;
    perrCount  = 0;
    serrCount  = 0;
    for (int i = 0; i < 4; i++) dataLog[i] = 8'h00;
  endtask

  // Sends one frame LSB first, p clock cycles per bit; must be entered just after a rising edge.
  task automatic applyStimulus(input logic [7:0] data, input logic usePar, input logic parBit,
                               input logic stopBit, input int p);
    logic [15:0] bits;
    int n;
    bits      = 16'hFFFF;
    bits[0]   = 1'b0;
    bits[8:1] = data;
    if (usePar) begin
      bits[9]  = parBit;
      bits[10] = stopBit;
      n = 11;
    end else begin
      bits[9] = stopBit;
      n = 10;
    end
    startCycle = cycle;
    for (int i = 0; i < n; i++) begin
      rx_in = bits[i];
      repeat (p) @(posedge clk);
      #1;
    end
    rx_in = 1'b1;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_data_out"}, 32'(data_out), 32'h0);
    checkOutput({tag, "_valid"}, 32'(data_valid), 32'h0);
    checkOutput({tag, "_perr"}, 32'(parity_error), 32'h0);
    checkOutput({tag, "_serr"}, 32'(stop_error), 32'h0);
  endtask

  initial begin
    reset         = 1'b0;
    rx_in         = 1'b1;
    prescale      = 6'd16;
    parity_enable = 1'b0;
    parity_type   = 1'b0;
    idle(3);
    checkIdleOutputs("reset");
    reset = 1'b1;
    idle(5);

    // 0xA5, P=16, no parity: latency (1+8+1)*16+1
    clearCounts();
    applyStimulus(8'hA5, 1'b0, 1'b0, 1'b1, 16);
    idle(4);
    checkOutput("a5_valid_cnt", 32'(validCount), 32'd1);
    checkOutput("a5_data", 32'(data_out), 32'hA5);
    checkOutput("a5_perr", 32'(perrCount), 32'd0);
    checkOutput("a5_serr", 32'(serrCount), 32'd0);
    checkOutput("a5_latency", 32'(validCycle - startCycle), 32'd161);

    // 0x3C has four ones: odd parity bit is 1
    parity_enable = 1'b1;
    parity_type   = 1'b1;
    clearCounts();
    applyStimulus(8'h3C, 1'b1, 1'b1, 1'b1, 16);
    idle(4);
    checkOutput("odd_ok_valid_cnt", 32'(validCount), 32'd1);
    checkOutput("odd_ok_data", 32'(data_out), 32'h3C);
    checkOutput("odd_ok_perr", 32'(perrCount), 32'd0);
    checkOutput("odd_ok_latency", 32'(validCycle - startCycle), 32'd177);

    clearCounts();
    applyStimulus(8'h3C, 1'b1, 1'b0, 1'b1, 16);
    idle(4);
    checkOutput("odd_bad_valid_cnt", 32'(validCount), 32'd0);
    checkOutput("odd_bad_perr", 32'(perrCount), 32'd1);
    checkOutput("odd_bad_serr", 32'(serrCount), 32'd0);
    checkOutput("odd_bad_data_hold", 32'(data_out), 32'h3C);

    // P=8: broken stop bit, then a good frame
    prescale      = 6'd8;
    parity_enable = 1'b0;
    clearCounts();
    applyStimulus(8'h81, 1'b0, 1'b0, 1'b0, 8);
    idle(4);
    checkOutput("stop_bad_valid_cnt", 32'(validCount), 32'd0);
    checkOutput("stop_bad_serr", 32'(serrCount), 32'd1);
    checkOutput("stop_bad_perr", 32'(perrCount), 32'd0);
    checkOutput("stop_bad_data_hold", 32'(data_out), 32'h3C);
    clearCounts();
    applyStimulus(8'h7E, 1'b0, 1'b0, 1'b1, 8);
    idle(4);
    checkOutput("p8_valid_cnt", 32'(validCount), 32'd1);
    checkOutput("p8_data", 32'(data_out), 32'h7E);
    checkOutput("p8_latency", 32'(validCycle - startCycle), 32'd81);

    // Short low glitch must be rejected silently
    prescale = 6'd16;
    clearCounts();
    rx_in = 1'b0;
    idle(4);
    rx_in = 1'b1;
    idle(60);
    checkOutput("glitch_valid_cnt", 32'(validCount), 32'd0);
    checkOutput("glitch_perr", 32'(perrCount), 32'd0);
    checkOutput("glitch_serr", 32'(serrCount), 32'd0);
    checkOutput("glitch_data_hold", 32'(data_out), 32'h7E);

    // Reset in the middle of the 4th data bit of 0xA5 (bits: 0, 1,0,1, then 0)
    clearCounts();
    rx_in = 1'b0; idle(16);
    rx_in = 1'b1; idle(16);
    rx_in = 1'b0; idle(16);
    rx_in = 1'b1; idle(16);
    rx_in = 1'b0; idle(8);
    reset = 1'b0;
    idle(1);
    checkIdleOutputs("midreset");
    idle(2);
    rx_in = 1'b1;
    reset = 1'b1;
    idle(40);
    checkOutput("midreset_valid_cnt", 32'(validCount), 32'd0);
    checkOutput("midreset_err_cnt", 32'(perrCount + serrCount), 32'd0);
    applyStimulus(8'h55, 1'b0, 1'b0, 1'b1, 16);
    idle(4);
    checkOutput("after_reset_valid_cnt", 32'(validCount), 32'd1);
    checkOutput("after_reset_data", 32'(data_out), 32'h55);

    // P=32 even parity, back-to-back: 0x01 -> parity 1, 0xFF -> parity 0
    prescale      = 6'd32;
    parity_enable = 1'b1;
    parity_type   = 1'b0;
    clearCounts();
    applyStimulus(8'h01, 1'b1, 1'b1, 1'b1, 32);
    applyStimulus(8'hFF, 1'b1, 1'b0, 1'b1, 32);
    idle(6);
    checkOutput("b2b_valid_cnt", 32'(validCount), 32'd2);
    checkOutput("b2b_first", 32'(dataLog[0]), 32'h01);
    checkOutput("b2b_second", 32'(dataLog[1]), 32'hFF);
    checkOutput("b2b_errs", 32'(perrCount + serrCount), 32'd0);
    checkOutput("b2b_data_out", 32'(data_out), 32'hFF);

    // Illegal prescale behaves as 16
    prescale      = 6'd5;
    parity_enable = 1'b0;
    clearCounts();
    applyStimulus(8'h5A, 1'b0, 1'b0, 1'b1, 16);
    idle(4);
    checkOutput("illegal_p_valid_cnt", 32'(validCount), 32'd1);
    checkOutput("illegal_p_data", 32'(data_out), 32'h5A);
    checkOutput("illegal_p_latency", 32'(validCycle - startCycle), 32'd161);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
